// File: rtl/spi_master_param.sv
// SPI master with parameterised word width, chip-select count and SCLK divider; all four CPOL/CPHA modes.
// Latency: CS asserts one cycle after accept; done pulses at cycle 1 + CLK_DIV*(2*DATA_W+1) after accept.
// Backpressure: start is only accepted while idle (including the done cycle); start while busy is dropped.
module spi_master_param #(
    parameter int DATA_W  = 16,
    parameter int NUM_CS  = 4,
    parameter int CLK_DIV = 2,
    parameter int CSW     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
    parameter int CW      = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [CSW-1:0]    cs_sel,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
    output logic              spi_sclk,
    output logic [NUM_CS-1:0] spi_cs_l,
    output logic              mosi,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic [CW-1:0]     bit_cnt
);

    localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EW   = $clog2(2 * DATA_W + 1);
    localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(CLK_DIV - 1);
    localparam logic [EW-1:0]   EDGE_LAST = EW'(2 * DATA_W);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

    state_t            state;
    logic [DIVW-1:0]   div_cnt;   // cycles spent in the current SCLK half-period
    logic [EW-1:0]     edge_cnt;  // SCLK edges already issued in this word
    logic              cpol_q;
    logic              cpha_q;
    logic [DATA_W-1:0] tx_sh;     // bits still to be placed on mosi, MSB first
    logic [DATA_W-1:0] rx_sh;     // bits collected from miso so far

    logic              tick;
    logic [EW-1:0]     edge_nxt;
    logic              lead_edge;
    logic              sample_edge;
    logic              shift_edge;
    logic [NUM_CS-1:0] cs_dec_l;

    // Edge bookkeeping: odd edges lead; the sampling edge flips with cpha.
    // With cpha=0 the last trailing edge must not advance mosi past the LSB.
    assign tick        = (div_cnt == DIV_LAST);
    assign edge_nxt    = edge_cnt + EW'(1);
    assign lead_edge   = edge_nxt[0];
    assign sample_edge = lead_edge ^ cpha_q;
    assign shift_edge  = cpha_q ? lead_edge : (!lead_edge && (edge_nxt != EDGE_LAST));

    // Decode the requested slave; an out-of-range index leaves every line deasserted.
    always_comb begin
        cs_dec_l = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (int'(cs_sel) == i) begin
                cs_dec_l[i] = 1'b0;
            end
        end
    end

    // Transfer FSM: all SPI pins and status outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            edge_cnt <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            spi_sclk <= 1'b0;
            spi_cs_l <= '1;
            mosi     <= 1'b0;
            rx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bit_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LEAD;
                        div_cnt  <= '0;
                        edge_cnt <= '0;
                        cpol_q   <= cpol;
                        cpha_q   <= cpha;
                        spi_sclk <= cpol;
                        spi_cs_l <= cs_dec_l;
                        busy     <= 1'b1;
                        bit_cnt  <= CW'(DATA_W);
                        rx_sh    <= '0;
                        if (cpha) begin
                            // MSB goes out on the first leading edge
                            mosi  <= 1'b0;
                            tx_sh <= tx_data;
                        end else begin
                            // MSB must be valid before the first (sampling) edge
                            mosi  <= tx_data[DATA_W-1];
                            tx_sh <= tx_data << 1;
                        end
                    end
                end
                LEAD, XFER: begin
                    div_cnt <= tick ? '0 : div_cnt + DIVW'(1);
                    if (tick) begin
                        edge_cnt <= edge_nxt;
                        spi_sclk <= ~spi_sclk;
                        if (sample_edge) begin
                            rx_sh   <= {rx_sh[DATA_W-2:0], miso};
                            bit_cnt <= bit_cnt - CW'(1);
                        end
                        if (shift_edge) begin
                            mosi  <= tx_sh[DATA_W-1];
                            tx_sh <= tx_sh << 1;
                        end
                        if (state == LEAD) begin
                            state <= XFER;
                        end else if (edge_nxt == EDGE_LAST) begin
                            state <= TRAIL;
                        end
                    end
                end
                TRAIL: begin
                    div_cnt <= tick ? '0 : div_cnt + DIVW'(1);
                    if (tick) begin
                        state    <= IDLE;
                        spi_cs_l <= '1;
                        spi_sclk <= cpol_q;
                        mosi     <= 1'b0;
                        rx_data  <= rx_sh;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_master_param.md
SPI_MASTER_PARAM -- requirements
Module: spi_master_param

Interface
REQ-001 The block SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-002 Parameter DATA_W, default 16, SHALL set the bits per transfer (legal range 2..64).
REQ-003 Parameter NUM_CS, default 4, SHALL set the number of chip-select lines (legal range 1..16).
REQ-004 Parameter CLK_DIV, default 2, SHALL set the SCLK half-period in clk cycles (legal range >=1).
REQ-005 Derived widths SHALL be CSW = max(1, clog2(NUM_CS)) and CW = clog2(DATA_W+1).
REQ-006 The ports SHALL be as follows:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  transfer request, sampled each clk
- cpol  in  1  SCLK idle level, latched at accept
- cpha  in  1  clock phase, latched at accept
- cs_sel  in  CSW  target slave index, latched at accept
- tx_data  in  DATA_W  word to send, latched at accept
- miso  in  1  serial data from slave
- spi_sclk  out  1  serial clock
- spi_cs_l  out  NUM_CS  active-low chip selects
- mosi  out  1  serial data to slave
- rx_data  out  DATA_W  last received word
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- bit_cnt  out  CW  bits remaining to sample

Function
REQ-007 The FSM SHALL have the states IDLE, LEAD, XFER, TRAIL, with transitions IDLE->LEAD->XFER->TRAIL->IDLE.
REQ-008 In IDLE, start=1 SHALL be accepted (cycle 0): latch tx_data, cpol, cpha, cs_sel; set bit_cnt=DATA_W; go to LEAD.
REQ-009 From cycle 1, spi_cs_l[cs_sel] SHALL be 0 and all other CS lines 1; busy SHALL be 1 from cycle 1 until the done cycle, exclusive.
REQ-010 If cs_sel >= NUM_CS, no CS line SHALL assert, but the transfer SHALL still run in full.
REQ-011 LEAD SHALL last CLK_DIV cycles, after which XFER SHALL produce 2*DATA_W SCLK edges, edge k (k=1..2*DATA_W) toggling spi_sclk at cycle 1+CLK_DIV*k.
REQ-012 Odd edges are leading edges and even edges are trailing edges; spi_sclk SHALL equal the latched cpol outside XFER.
REQ-013 Transfers SHALL be MSB first on both mosi and rx.
REQ-014 With cpha=0, mosi SHALL carry tx MSB from cycle 1; miso SHALL be sampled on leading edges; mosi SHALL advance on trailing edges except the last.
REQ-015 With cpha=1, mosi SHALL drive the next bit on each leading edge (MSB on edge 1); miso SHALL be sampled on trailing edges.
REQ-016 bit_cnt SHALL decrement by 1 on each sampling edge, reaching 0 at the last sample.
REQ-017 TRAIL SHALL last CLK_DIV cycles; then, at cycle 1+CLK_DIV*(2*DATA_W+1), all CS SHALL go high, rx_data SHALL update with the received word, done=1 for one cycle, busy=0, and the FSM SHALL return to IDLE.
REQ-018 rx_data SHALL hold its previous value throughout a transfer; mosi SHALL be 0 in IDLE.
REQ-019 start while busy=1 SHALL be ignored, with no effect on the current transfer.
REQ-020 start=1 in the done cycle SHALL be accepted (back-to-back), so CS is high for exactly one cycle between words.
REQ-021 Changes to cpol, cpha, cs_sel or tx_data after accept SHALL NOT affect the transfer in progress.

Reset
REQ-022 On reset=1 at a clk edge, outputs SHALL become: spi_cs_l all ones, spi_sclk=0, mosi=0, rx_data=0, busy=0, done=0, bit_cnt=0; state IDLE; latched cpol=0.
REQ-023 Reset mid-transfer SHALL abort the transfer without a done pulse and without updating rx_data (rx_data=0).

Verification
REQ-024 Loopback, mode 0: DATA_W=16, CLK_DIV=2, miso=mosi, tx_data=0xA5C3, start at cycle 0 -> 32 edges, done at cycle 67, rx_data=0xA5C3.
REQ-025 Mode 3 (cpol=1, cpha=1), slave model returns 0x1234 -> spi_sclk idles 1, rx_data=0x1234; slave captures tx 0xBEEF on rising edges.
REQ-026 cs_sel=2, NUM_CS=4 -> only spi_cs_l[2]=0 during cycles 1..66; cs_sel=5 -> spi_cs_l stays 4'b1111 while transfer completes.
REQ-027 start pulsed at cycle 10 of an active transfer -> ignored, single done; start held during done cycle -> second transfer, CS high for exactly one cycle.
REQ-028 reset at cycle 20 mid-transfer -> next cycle all reset values, no done; a new start afterwards completes normally.
